// File: rtl/gcd_pkg.sv
// Shared constants and record types for the round-robin GCD scheduler.
// Optional watchdog is enabled with the GCD_SCHED_TIMEOUT_EN macro.
package gcd_pkg;

  localparam int DEF_W = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct packed {
    logic [DEF_W-1:0] a;
    logic [DEF_W-1:0] b;
  } gcd_req_t;

  typedef struct packed {
    logic [DEF_W-1:0] data;
    logic             err;
  } gcd_rsp_t;

endpackage

// File: rtl/gcd_rr_scheduler_if.sv
// Request/response handshakes plus the engine start/done link of the GCD scheduler.
// The scheduler uses the slave modport; requesters and the engine use master.
interface gcd_rr_scheduler_if import gcd_pkg::*; #(
  parameter int NREQ = 4,
  parameter int W    = DEF_W
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;

  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;

  logic              eng_start;
  logic [W-1:0]      eng_a;
  logic [W-1:0]      eng_b;
  logic              eng_done;
  logic [W-1:0]      eng_result;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, eng_done, eng_result,
    output req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_a, eng_b
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, eng_done, eng_result,
    input  req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_a, eng_b
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, with wrap.
// Reusable for any shared datapath; grant is one-hot or zero.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx
);

  logic          found;
  int            cand;
  logic [PW-1:0] cand_idx;

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cand_idx = PW'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/gcd_rr_scheduler.sv
// Round-robin scheduler sharing one subtractive GCD engine among NREQ requesters.
// Define GCD_SCHED_TIMEOUT_EN to add a WAIT-state watchdog that reports rsp_err.
module gcd_rr_scheduler import gcd_pkg::*; #(
  parameter int NREQ       = 4,
  parameter int W          = DEF_W,
  parameter int TMO_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  gcd_rr_scheduler_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]      state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   ptr_next;
  logic [NREQ-1:0] grant;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W-1:0]    result;
  logic            req_fire;
  logic            zero_op;
  logic            rsp_accept;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign sel_a    = bus.req_a[int'(grant_idx)*W +: W];
  assign sel_b    = bus.req_b[int'(grant_idx)*W +: W];
  assign zero_op  = (sel_a == '0) || (sel_b == '0);
  assign req_fire = (state == S_IDLE) && (grant != '0);
  assign ptr_next = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  assign rsp_accept = bus.rsp_ready[owner];

  assign bus.req_ready = (state == S_IDLE) ? grant : '0;
  assign bus.rsp_valid = (state == S_RESP) ? (NREQ'(1) << owner) : '0;
  assign bus.rsp_data  = result;
  assign bus.eng_start = (state == S_ISSUE);
  assign bus.eng_a     = op_a;
  assign bus.eng_b     = op_b;

`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          err_q;

  assign tmo_hit     = (state == S_WAIT) && !bus.eng_done && (tmo_cnt == TW'(TMO_CYCLES - 1));
  assign bus.rsp_err = err_q;

  // Count only while waiting on the engine; any other state rearms the watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state != S_WAIT) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == S_IDLE) begin
      err_q <= 1'b0;
    end else if (tmo_hit) begin
      err_q <= 1'b1;
    end
  end
`else
  logic tmo_hit;

  assign tmo_hit     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // Zero operands bypass the engine since subtraction would never converge on them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_fire) begin
            owner  <= grant_idx;
            rr_ptr <= ptr_next;
            if (zero_op) begin
              result <= sel_a | sel_b;
              state  <= S_RESP;
            end else begin
              op_a  <= sel_a;
              op_b  <= sel_b;
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.eng_done) begin
            result <= bus.eng_result;
            state  <= S_RESP;
          end else if (tmo_hit) begin
            result <= '0;
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_accept) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Scoreboard bench for gcd_rr_scheduler with a behavioural k-cycle GCD engine.
// Timeout scenario runs only when GCD_SCHED_TIMEOUT_EN is defined.
module tb_gcd_rr_scheduler;
  import gcd_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int TMO  = 16;
  localparam int K    = 5;

  typedef struct {
    int       owner;
    gcd_rsp_t rsp;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic engine_hang = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_count = 0;
  int last_start_cyc = -1;

  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_oi;

  logic [W-1:0] eng_res;
  int           eng_cnt;
  logic         eng_busy;

  gcd_rr_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

  gcd_rr_scheduler #(.NREQ(NREQ), .W(W), .TMO_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.eng_start) begin
      start_count    <= start_count + 1;
      last_start_cyc <= cyc;
    end
  end

  function automatic logic [W-1:0] gcd_model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    for (int i = 0; i < 64 && y != '0; i++) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Engine answers K cycles after the start pulse and holds done until the next start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_busy       <= 1'b0;
      eng_cnt        <= 0;
      eng_res        <= '0;
      bus.eng_done   <= 1'b0;
      bus.eng_result <= '0;
    end else if (bus.eng_start) begin
      bus.eng_done <= 1'b0;
      eng_busy     <= !engine_hang;
      eng_cnt      <= K - 1;
      eng_res      <= gcd_model(bus.eng_a, bus.eng_b);
    end else if (eng_busy) begin
      if (eng_cnt == 1) begin
        bus.eng_done   <= 1'b1;
        bus.eng_result <= eng_res;
        eng_busy       <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor pops the scoreboard on every accepted response.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid != '0) begin
      if ($countones(bus.rsp_valid) != 1) begin
        check_output("rsp_valid_onehot", $countones(bus.rsp_valid), 1);
      end else begin
        mon_oi = 0;
        for (int i = 0; i < NREQ; i++) begin
          if (bus.rsp_valid[i]) mon_oi = i;
        end
        if (bus.rsp_ready[mon_oi]) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_rsp", 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check_output("rsp_owner", mon_oi, mon_e.owner);
            check_output("rsp_data", bus.rsp_data, mon_e.rsp.data);
            check_output("rsp_err", bus.rsp_err, mon_e.rsp.err);
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_req_ready"}, bus.req_ready, 0);
    check_output({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check_output({tag, "_rsp_data"}, bus.rsp_data, 0);
    check_output({tag, "_rsp_err"}, bus.rsp_err, 0);
    check_output({tag, "_eng_start"}, bus.eng_start, 0);
    check_output({tag, "_eng_a"}, bus.eng_a, 0);
    check_output({tag, "_eng_b"}, bus.eng_b, 0);
  endtask

  task automatic push_exp(input int owner, input logic [W-1:0] data, input logic err);
    exp_t e;
    e.owner    = owner;
    e.rsp.data = data;
    e.rsp.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_valid[idx]      = 1'b1;
    bus.req_a[idx*W +: W]   = a;
    bus.req_b[idx*W +: W]   = b;
  endtask

  // Single isolated transaction with latency and engine-usage checks.
  task automatic apply_stimulus(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] exp_data, input logic exp_err,
                                input int exp_lat, input int exp_starts);
    int t, starts0, seen;
    push_exp(idx, exp_data, exp_err);
    @(posedge clk); #1;
    starts0 = start_count;
    set_req(idx, a, b);
    t = cyc;
    @(negedge clk);
    check_output($sformatf("req_ready_grant%0d", idx), bus.req_ready, 32'(1) << idx);
    @(posedge clk); #1;
    bus.req_valid[idx] = 1'b0;
    seen = -1000;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.rsp_valid[idx]) begin
        seen = cyc;
        break;
      end
    end
    check_output($sformatf("rsp_latency_req%0d", idx), seen - t, exp_lat);
    check_output("eng_start_count", start_count - starts0, exp_starts);
    if (exp_starts == 1) begin
      check_output("eng_start_cycle", last_start_cyc - t, 1);
      check_output("eng_a", bus.eng_a, a);
      check_output("eng_b", bus.eng_b, b);
    end
  endtask

  task automatic run_until_drained(input int budget);
    logic [NREQ-1:0] acc;
    int n;
    n = 0;
    while ((bus.req_valid != '0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk); #1;
      bus.req_valid = bus.req_valid & ~acc;
      n++;
    end
    check_output("drain_queue_empty", exp_q.size(), 0);
    check_output("drain_valid_clear", bus.req_valid, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("pulse_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got %0d expected %0d", cyc, 0);
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '1;

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single engine transaction: gcd(48,18)=6, response at T+7.
    apply_stimulus(0, 16'd48, 16'd18, 16'd6, 1'b0, 7, 1);

    // Zero operands resolve locally one cycle after acceptance.
    apply_stimulus(2, 16'd0, 16'd25, 16'd25, 1'b0, 1, 0);
    apply_stimulus(1, 16'd30, 16'd0, 16'd30, 1'b0, 1, 0);
    apply_stimulus(3, 16'd0, 16'd0, 16'd0, 1'b0, 1, 0);

    // All four requesters at once from rr_ptr=0: served 0,1,2,3.
    pulse_reset();
    set_req(0, 16'd12, 16'd8);
    set_req(1, 16'd21, 16'd14);
    set_req(2, 16'd35, 16'd10);
    set_req(3, 16'd9, 16'd6);
    push_exp(0, 16'd4, 1'b0);
    push_exp(1, 16'd7, 1'b0);
    push_exp(2, 16'd5, 1'b0);
    push_exp(3, 16'd3, 1'b0);
    run_until_drained(200);

    // Pointer wrapped to 0: req1 before req3.
    set_req(1, 16'd27, 16'd18);
    set_req(3, 16'd64, 16'd48);
    push_exp(1, 16'd9, 1'b0);
    push_exp(3, 16'd16, 1'b0);
    run_until_drained(100);

    // Back-pressure on requester 2 while requester 0 waits.
    bus.rsp_ready[2] = 1'b0;
    push_exp(2, 16'd8, 1'b0);
    push_exp(0, 16'd5, 1'b0);
    set_req(2, 16'd40, 16'd16);
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b0;
    set_req(0, 16'd15, 16'd10);
    for (int n = 0; n < 40 && !bus.rsp_valid[2]; n++) @(negedge clk);
    check_output("bp_rsp_valid_seen", bus.rsp_valid, 4);
    for (int i = 0; i < 10; i++) begin
      check_output("bp_rsp_data_stable", bus.rsp_data, 8);
      check_output("bp_req_ready_low", bus.req_ready, 0);
      check_output("bp_rsp_valid_held", bus.rsp_valid, 4);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready[2] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_output("bp_req0_granted_next", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    run_until_drained(100);

    // Asynchronous reset while waiting on the engine discards the transaction.
    @(posedge clk); #1;
    set_req(1, 16'd81, 16'd27);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    for (int n = 0; n < 20 && !bus.eng_start; n++) @(negedge clk);
    check_output("rst_wait_eng_start", bus.eng_start, 1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(2, 16'd100, 16'd75, 16'd25, 1'b0, 7, 1);

`ifdef GCD_SCHED_TIMEOUT_EN
    // Hung engine: error response after TMO WAIT cycles, then normal service.
    engine_hang = 1'b1;
    apply_stimulus(3, 16'd20, 16'd8, 16'd0, 1'b1, TMO + 2, 1);
    engine_hang = 1'b0;
    apply_stimulus(3, 16'd20, 16'd8, 16'd4, 1'b0, 7, 1);
`endif

    repeat (3) @(negedge clk);
    check_output("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
